// File: rtl/sprite_line_scheduler_pkg.sv
// sprite_line_scheduler_pkg: shared sizes, sprite word fields, FSM states and span test
package sprite_line_scheduler_pkg;
  localparam int NUM_SPRITES = 32;
  localparam int ADDR_W = 5;
  localparam int MAX_PER_LINE = 4;
  localparam int SPRITE_SIZE = 20;
  localparam int SIZE_X = 10;
  localparam int SIZE_Y = 10;
  localparam int EN_BIT = 29;
  localparam int X_MSB = 28;
  localparam int X_LSB = 19;
  localparam int Y_MSB = 18;
  localparam int Y_LSB = 9;
  localparam int OFF_MSB = 8;
  localparam int OFF_LSB = 0;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  // one bit wider than the coordinate so p<s wraps to a large value and misses
  function automatic logic in_span(input logic [SIZE_X-1:0] p, input logic [SIZE_X-1:0] s);
    logic [SIZE_X:0] d;
    d = {1'b0, p} - {1'b0, s};
    return d < (SIZE_X+1)'(SPRITE_SIZE);
  endfunction
endpackage

// File: rtl/sprite_line_scheduler_if.sv
// sprite_line_scheduler_if: line/register-bus/print signals of the sprite scheduler
interface sprite_line_scheduler_if import sprite_line_scheduler_pkg::*; ;
  logic new_line;
  logic [SIZE_Y-1:0] next_y;
  logic [ADDR_W-1:0] reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic active_area;
  logic [SIZE_X-1:0] pixel_x;
  logic [31:0] print_data;
  logic print_valid;
  logic line_ovf;
  logic scan_late;
  logic scan_busy;
  modport master (
    input new_line, next_y, reg_rd_data, active_area, pixel_x,
    output reg_rd_addr, print_data, print_valid, line_ovf, scan_late, scan_busy
  );
  modport slave (
    output new_line, next_y, reg_rd_data, active_area, pixel_x,
    input reg_rd_addr, print_data, print_valid, line_ovf, scan_late, scan_busy
  );
endinterface

// File: rtl/sprite_line_scheduler_slot_bank.sv
// sprite_slot_bank: MAX_PER_LINE sprite slots filled in order, with valid bits and overflow flag
module sprite_slot_bank import sprite_line_scheduler_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_we,
  input  logic [31:0] i_data,
  output logic [31:0] o_slot [MAX_PER_LINE],
  output logic [MAX_PER_LINE-1:0] o_valid,
  output logic o_ovf
);
  localparam int CW = $clog2(MAX_PER_LINE) + 1;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_slot [MAX_PER_LINE];
  logic [MAX_PER_LINE-1:0] r_valid;
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
      r_valid <= '0;
      r_ovf <= 1'b0;
    end else if (i_we) begin
      if (r_cnt < CW'(MAX_PER_LINE)) begin
        r_slot[r_cnt[CW-2:0]] <= i_data;
        r_valid[r_cnt[CW-2:0]] <= 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end else r_ovf <= 1'b1;
    end
  end
  assign o_slot = r_slot;
  assign o_valid = r_valid;
  assign o_ovf = r_ovf;
endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-line sprite scan into a back bank, pixel-wise selection from the front bank
module sprite_line_scheduler import sprite_line_scheduler_pkg::*; (
  input logic clk,
  input logic reset,
  sprite_line_scheduler_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SPRITES - 1);
  state_t r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [SIZE_Y-1:0] r_y;
  logic r_sel, r_late, r_pv;
  logic [31:0] r_pd;
  logic w_eval, w_hit, w_pv;
  logic [31:0] w_pd;
  logic [31:0] w_slot0 [MAX_PER_LINE];
  logic [31:0] w_slot1 [MAX_PER_LINE];
  logic [31:0] w_fslot [MAX_PER_LINE];
  logic [MAX_PER_LINE-1:0] w_valid0, w_valid1, w_fvalid;
  logic w_ovf0, w_ovf1;
  // address 0's word arrives in the cycle issuing address 1; a new_line drops the word in flight
  assign w_eval = !bus.new_line && ((r_state == SCAN && r_addr != '0) || r_state == DRAIN);
  assign w_hit = w_eval && bus.reg_rd_data[EN_BIT] && in_span(r_y, bus.reg_rd_data[Y_MSB:Y_LSB]);
  sprite_slot_bank u_bank0 (
    .clk(clk), .reset(reset), .i_clr(bus.new_line && !r_sel), .i_we(w_hit && r_sel),
    .i_data(bus.reg_rd_data), .o_slot(w_slot0), .o_valid(w_valid0), .o_ovf(w_ovf0)
  );
  sprite_slot_bank u_bank1 (
    .clk(clk), .reset(reset), .i_clr(bus.new_line && r_sel), .i_we(w_hit && !r_sel),
    .i_data(bus.reg_rd_data), .o_slot(w_slot1), .o_valid(w_valid1), .o_ovf(w_ovf1)
  );
  assign w_fslot = r_sel ? w_slot1 : w_slot0;
  assign w_fvalid = r_sel ? w_valid1 : w_valid0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_y <= '0;
      r_sel <= 1'b0;
      r_late <= 1'b0;
    end else if (bus.new_line) begin
      r_late <= r_late || r_state != IDLE;
      r_state <= SCAN;
      r_addr <= '0;
      r_y <= bus.next_y;
      r_sel <= !r_sel;
    end else begin
      r_state <= (r_state == SCAN && r_addr == LAST) ? DRAIN : (r_state == DRAIN) ? IDLE : r_state;
      r_addr <= (r_state == SCAN && r_addr != LAST) ? r_addr + 1'b1 : r_addr;
    end
  end
  always_comb begin
    w_pv = 1'b0;
    w_pd = '0;
    for (int i = MAX_PER_LINE - 1; i >= 0; i--)
      if (w_fvalid[i] && in_span(bus.pixel_x, w_fslot[i][X_MSB:X_LSB])) begin
        w_pv = 1'b1;
        w_pd = w_fslot[i];
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pv <= 1'b0;
      r_pd <= '0;
    end else begin
      r_pv <= bus.active_area && w_pv;
      r_pd <= (bus.active_area && w_pv) ? w_pd : '0;
    end
  end
  assign bus.reg_rd_addr = r_addr;
  assign bus.print_valid = r_pv;
  assign bus.print_data = r_pd;
  assign bus.line_ovf = r_sel ? w_ovf1 : w_ovf0;
  assign bus.scan_late = r_late;
  assign bus.scan_busy = r_state != IDLE;
endmodule
